// File: rtl/ssd_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package ssd_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DIGITS   = 8;
    localparam int NIBBLE_W = 4;
    localparam int VALUE_W  = DIGITS * NIBBLE_W;

    // Index width for n items; never below one bit so single-value ranges stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ssd_rr_pick.sv
// Combinational round-robin picker: first asserted request after i_last, wrapping.
module ssd_rr_pick
    import ssd_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW  = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [IW-1:0]   o_winner,
    output logic            o_any
);

    // Scan from the farthest candidate to the nearest so the nearest one overwrites.
    // NOTE: every output gets a default before the loop, so no latch is inferred.
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            int idx;
            idx = (int'(i_last) + k) % NREQ;
            if (i_req[idx]) begin
                o_winner = IW'(idx);
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssd_display_arbiter.sv
// Round-robin sharing of the eight-digit display; each granted value is held for HOLD_CYCLES.
// Optional SSD_ARB_LOCK_EN adds a lock input that freezes the hold timer and blocks new grants.
module ssd_display_arbiter
    import ssd_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                    clk,
    input  logic                    rstn,
`ifdef SSD_ARB_LOCK_EN
    input  logic                    lock,
`endif
    input  logic [NREQ-1:0]         req,
    input  logic [VALUE_W*NREQ-1:0] data,
    output logic [NREQ-1:0]         ack,
    output logic [NIBBLE_W-1:0]     bnum0,
    output logic [NIBBLE_W-1:0]     bnum1,
    output logic [NIBBLE_W-1:0]     bnum2,
    output logic [NIBBLE_W-1:0]     bnum3,
    output logic [NIBBLE_W-1:0]     bnum4,
    output logic [NIBBLE_W-1:0]     bnum5,
    output logic [NIBBLE_W-1:0]     bnum6,
    output logic [NIBBLE_W-1:0]     bnum7,
    output logic [2:0]              grant_id,
    output logic                    grant_valid,
    output logic                    busy
);

    localparam int IW    = idx_w(NREQ);
    localparam int CNT_W = idx_w(HOLD_CYCLES);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IW-1:0]      r_last;
    logic [IW-1:0]      r_grant_id;
    logic [VALUE_W-1:0] r_disp;
    logic [NREQ-1:0]    r_ack;
    logic               r_grant_valid;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IW-1:0]      w_winner;
    logic               w_any;
    logic               w_lock;
    logic               w_expire;
    logic               w_grant;

`ifdef SSD_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    ssd_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req    (req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_expire    = (r_state == HOLD) && (r_cnt == CNT_W'(HOLD_CYCLES - 1));
        w_grant     = !w_lock && w_any && ((r_state == IDLE) || w_expire);
        if (w_grant) begin
            w_state_nxt = HOLD;
            w_cnt_nxt   = '0;
        end else if (r_state == HOLD && !w_lock) begin
            if (w_expire) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_last        <= IW'(NREQ - 1);
            r_grant_id    <= '0;
            r_disp        <= '0;
            r_ack         <= '0;
            r_grant_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= '0;
            if (w_grant) begin
                r_disp        <= data[VALUE_W*int'(w_winner) +: VALUE_W];
                r_ack         <= NREQ'(1) << w_winner;
                r_grant_id    <= w_winner;
                r_last        <= w_winner;
                r_grant_valid <= 1'b1;
            end
        end
    end

    assign ack         = r_ack;
    assign grant_id    = 3'(r_grant_id);
    assign grant_valid = r_grant_valid;
    assign busy        = (r_state == HOLD);

    assign bnum0 = r_disp[0*NIBBLE_W +: NIBBLE_W];
    assign bnum1 = r_disp[1*NIBBLE_W +: NIBBLE_W];
    assign bnum2 = r_disp[2*NIBBLE_W +: NIBBLE_W];
    assign bnum3 = r_disp[3*NIBBLE_W +: NIBBLE_W];
    assign bnum4 = r_disp[4*NIBBLE_W +: NIBBLE_W];
    assign bnum5 = r_disp[5*NIBBLE_W +: NIBBLE_W];
    assign bnum6 = r_disp[6*NIBBLE_W +: NIBBLE_W];
    assign bnum7 = r_disp[7*NIBBLE_W +: NIBBLE_W];

endmodule
